fifo_burst_reader: RTL and testbench

//  Read-side consumer for the dual-clock FIFO. Runs entirely in the FIFO read-clock domain.

---
 rtl/fifo_burst_reader_pkg.sv | 12 +
 rtl/fifo_skid_buf.sv | 67 ++++++
 rtl/fifo_burst_reader.sv | 125 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the burst reader: FSM state encoding and output buffer depth.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] BUF_FULL = 2'd2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry data+last buffer; entry 0 is the head presented downstream.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_data0, r_data1;
  logic                  r_last0, r_last1;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_count <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end else begin
            r_data1 <= i_data;
            r_last1 <= i_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the incoming word lands behind whatever remains.
          if (r_count == BUF_FULL) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= i_data;
            r_last1 <= i_last;
          end else begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_data0;
  assign o_last  = r_last0;
  assign o_count = r_count;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst consumer for the FIFO read side: pops cmd_len words and streams them with m_last.
// Optional starvation abort enabled by defining FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  input  logic [DATA_WIDTH-1:0]    fifo_rdata,
  output logic                     fifo_re,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [LEN_WIDTH-1:0]     words_left,
  output logic                     timeout
);

  state_t                r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_words_left;
  logic [1:0]            w_count;
  logic [DATA_WIDTH-1:0] w_buf_data;
  logic                  w_buf_last;
  logic                  w_pop_fifo, w_buf_pop, w_cmd_acc, w_abort;

  // fifo_re depends only on registered state and fifo_empty, never on m_ready.
  assign w_pop_fifo = (r_state == ST_BURST) && !fifo_empty &&
                      (r_words_left != '0) && (w_count != BUF_FULL);
  assign w_buf_pop  = m_valid && m_ready;
  assign w_cmd_acc  = cmd_valid && (r_state == ST_IDLE);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                     r_timeout;

  assign w_abort = (r_state == ST_BURST) && !w_pop_fifo &&
                   (timeout_cycles != '0) && (r_to_cnt == timeout_cycles);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_cmd_acc) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == ST_BURST) begin
      if (w_abort)
        r_timeout <= 1'b1;
      if (w_pop_fifo)
        r_to_cnt <= '0;
      else if (fifo_empty)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_cycles;
  assign w_abort          = 1'b0;
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_words_left <= '0;
    end else begin
      r_state <= w_next;
      if (w_cmd_acc)
        r_words_left <= cmd_len;
      else if (w_abort)
        r_words_left <= '0;
      else if (w_pop_fifo)
        r_words_left <= r_words_left - 1'b1;
    end
  end

  // BURST leaves on its final pop so DRAIN can release on the m_last handshake itself.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_cmd_acc && (cmd_len != '0)) w_next = ST_BURST;
      ST_BURST:
        if (w_abort || (w_pop_fifo && (r_words_left == LEN_WIDTH'(1)))) w_next = ST_DRAIN;
      ST_DRAIN:
        if ((w_count == 2'd0) || ((w_count == 2'd1) && m_ready)) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_pop_fifo),
    .i_data (fifo_rdata),
    .i_last (r_words_left == LEN_WIDTH'(1)),
    .i_pop  (w_buf_pop),
    .o_data (w_buf_data),
    .o_last (w_buf_last),
    .o_count(w_count)
  );

  assign fifo_re    = w_pop_fifo;
  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign words_left = r_words_left;
  assign m_valid    = (w_count != 2'd0);
  assign m_data     = w_buf_data;
  assign m_last     = w_buf_last && m_valid;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader; timeout scenario follows FIFO_BURST_READER_TIMEOUT_EN.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_re;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_len = 16'h0;
  logic [7:0]  timeout_cycles = 8'h0;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] words_left;
  logic        timeout;

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .LEN_WIDTH(16),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_re(fifo_re), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .timeout_cycles(timeout_cycles), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .words_left(words_left), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int re_cnt = 0, hs_count = 0, first_hs = -1, last_hs = -1, occ = 0;
  bit rdy_mode = 1'b0, rdy_level = 1'b1;
  int pidx = 0;

  function automatic void fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  function automatic void fifo_put(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_refresh();
  endfunction

  // Show-ahead FIFO model: a pop seen at the edge takes effect just after it.
  initial begin : fifo_model
    logic pop_now;
    forever begin
      @(posedge clk);
      pop_now = fifo_re;
      #1;
      if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  initial begin : ready_gen
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode) begin
        m_ready = (pidx % 3 == 0);
        pidx++;
      end else begin
        m_ready = rdy_level;
      end
    end
  end

  initial begin : monitor
    logic [8:0] e;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        occ = 0;
        prev_stall = 1'b0;
      end else begin
        if (fifo_re) begin
          re_cnt++;
          total++;
          if (fifo_empty || occ >= 2) begin
            bad++;
            $display("FAIL fifo_re_guard: cyc=%0d empty=%0b occ=%0d, required empty=0 occ<2",
                     cyc, fifo_empty, occ);
          end
        end
        if (prev_stall) begin
          total++;
          if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
            bad++;
            $display("FAIL hold: cyc=%0d got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                     cyc, m_valid, m_data, m_last, prev_data, prev_last);
          end
        end
        if (m_valid && m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL stream_extra: cyc=%0d got d=%02h l=%0b, required no word", cyc, m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              bad++;
              $display("FAIL stream_word: cyc=%0d got d=%02h l=%0b, required d=%02h l=%0b",
                       cyc, m_data, m_last, e[7:0], e[8]);
            end
          end
          if (hs_count == 0) first_hs = cyc;
          last_hs = cyc;
          hs_count++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        occ = occ + (fifo_re ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    re_cnt = 0; hs_count = 0; first_hs = -1; last_hs = -1;
  endtask

  task automatic send_cmd(input logic [15:0] len);
    cmd_len = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && cmd_ready === 1'b1 && m_valid === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_done: pending=%0d cmd_ready=%0b after %0d cycles, required pending=0 cmd_ready=1",
               name, exp_q.size(), cmd_ready, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    reset = 1'b1;
    tick();
    tick();
    obs = {fifo_re, cmd_ready, m_valid, m_data, m_last, busy, words_left, timeout};
    total++;
    if (obs !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got %08h, required %08h", obs,
               {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_burst4();
    int acc;
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      fifo_put(8'h10 + 8'(i));
      exp_q.push_back({(i == 3), 8'h10 + 8'(i)});
    end
    send_cmd(16'd4);
    acc = cyc;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL burst4_cmd_ready: got %0b, required 1", cmd_ready);
    end
    total++;
    if (re_cnt != 4 || hs_count != 4) begin
      bad++; $display("FAIL burst4_counts: got re=%0d hs=%0d, required 4 4", re_cnt, hs_count);
    end
    total++;
    if (first_hs != acc + 1 || last_hs != acc + 4) begin
      bad++;
      $display("FAIL burst4_timing: got first=%0d last=%0d, required %0d %0d",
               first_hs, last_hs, acc + 1, acc + 4);
    end
    tick();
  endtask

  task automatic test_stall();
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      fifo_put(8'h20 + 8'(i));
      exp_q.push_back({(i == 7), 8'h20 + 8'(i)});
    end
    pidx = 0;
    rdy_mode = 1'b1;
    send_cmd(16'd8);
    wait_done(100, "stall");
    rdy_mode = 1'b0;
    tick();
    total++;
    if (hs_count != 8 || re_cnt != 8) begin
      bad++; $display("FAIL stall_counts: got hs=%0d re=%0d, required 8 8", hs_count, re_cnt);
    end
  endtask

  task automatic test_underrun();
    clear_stats();
    fifo_put(8'h30);
    fifo_put(8'h31);
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'h30 + 8'(i)});
    send_cmd(16'd5);
    total++;
    if (words_left !== 16'd5) begin
      bad++; $display("FAIL underrun_latch: got words_left=%0d, required 5", words_left);
    end
    repeat (10) tick();
    total++;
    if (words_left !== 16'd3 || fifo_re !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL underrun_wait: got wl=%0d re=%0b busy=%0b, required wl=3 re=0 busy=1",
               words_left, fifo_re, busy);
    end
    for (int i = 2; i < 5; i++) fifo_put(8'h30 + 8'(i));
    wait_done(50, "underrun");
    total++;
    if (hs_count != 5 || re_cnt != 5 || words_left !== 16'd0) begin
      bad++;
      $display("FAIL underrun_counts: got hs=%0d re=%0d wl=%0d, required 5 5 0",
               hs_count, re_cnt, words_left);
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    fifo_put(8'h55);
    send_cmd(16'd0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
        bad++;
        $display("FAIL zero_len_idle: got rdy=%0b busy=%0b valid=%0b, required 1 0 0",
                 cmd_ready, busy, m_valid);
      end
      tick();
    end
    total++;
    if (re_cnt != 0 || hs_count != 0) begin
      bad++; $display("FAIL zero_len_counts: got re=%0d hs=%0d, required 0 0", re_cnt, hs_count);
    end
    fifo_q.delete();
    fifo_refresh();
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    clear_stats();
    rdy_level = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) fifo_put(8'h40 + 8'(i));
    send_cmd(16'd6);
    repeat (4) tick();
    total++;
    if (words_left !== 16'd4 || m_valid !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: got wl=%0d valid=%0b, required 4 1", words_left, m_valid);
    end
    reset = 1'b1;
    tick();
    obs = {fifo_re, cmd_ready, m_valid, m_data, m_last, busy, words_left, timeout};
    total++;
    if (obs !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_values: got %08h, required %08h", obs,
               {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0});
    end
    reset = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    rdy_level = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    clear_stats();
    timeout_cycles = 8'd8;
    fifo_put(8'h60);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    exp_q.push_back({1'b0, 8'h60});
    send_cmd(16'd4);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (n >= 40) begin
      bad++; $display("FAIL timeout_assert: got timeout=%0b after %0d cycles, required 1", timeout, n);
    end
    total++;
    if (words_left !== 16'd0 || hs_count != 1) begin
      bad++; $display("FAIL timeout_trunc: got wl=%0d hs=%0d, required 0 1", words_left, hs_count);
    end
    wait_done(10, "timeout");
    total++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky: got timeout=%0b busy=%0b, required 1 0", timeout, busy);
    end
    send_cmd(16'd0);
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: got %0b, required 0", timeout);
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 8'h60 + 8'(i)});
    send_cmd(16'd4);
    repeat (20) tick();
    total++;
    if (timeout !== 1'b0 || busy !== 1'b1 || hs_count != 1) begin
      bad++;
      $display("FAIL no_timeout_wait: got timeout=%0b busy=%0b hs=%0d, required 0 1 1",
               timeout, busy, hs_count);
    end
    for (int i = 1; i < 4; i++) fifo_put(8'h60 + 8'(i));
    wait_done(40, "no_timeout");
    total++;
    if (timeout !== 1'b0 || hs_count != 4) begin
      bad++; $display("FAIL no_timeout_done: got timeout=%0b hs=%0d, required 0 4", timeout, hs_count);
    end
`endif
    timeout_cycles = 8'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_burst4();
    test_stall();
    test_underrun();
    test_zero_len();
    test_reset_mid();
    test_timeout();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drained: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
